// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared ISA definitions for the 9-bit instruction set and the
// fetch stage. Holds the instruction/PC widths, the halt encoding, the
// instruction field positions and the fetch state enum.
package fetch_unit_pkg;

  localparam int INSTR_W = 9;
  localparam int PC_W    = 16;

  localparam logic [INSTR_W-1:0] HALT_INSTR_ENC = 9'b110110000;

  // Instruction field positions
  localparam int FMT_BIT  = 8;
  localparam int OPC_HI   = 7;
  localparam int OPC_LO   = 4;
  localparam int SIGN_BIT = 3;
  localparam int OPND_HI  = 2;
  localparam int OPND_LO  = 0;
  localparam int IMM_HI   = 7;
  localparam int IMM_LO   = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// pc_reg: program counter register with load / increment / hold.
// Increment wraps modulo 2^16 with no flag.
// Ports:
//   clk, reset   clock, synchronous active-high reset (PC <= RESET_PC)
//   i_load       load i_target (has priority over i_inc)
//   i_target     absolute load value
//   i_inc        increment by one
//   o_pc         current PC
module pc_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_load,
  input  logic [PC_W-1:0] i_target,
  input  logic            i_inc,
  output logic [PC_W-1:0] o_pc
);

  logic [PC_W-1:0] r_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= i_target;
    end else if (i_inc) begin
      r_pc <= r_pc + 16'd1;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage between the combinational 9-bit ROM and
// decode. Owns the PC (via pc_reg), drives the ROM address and latches the
// returned word into the IR with a valid bit. Handles start, stall, taken
// branches (one-bubble squash) and the halt instruction.
// Optional feature: define FETCH_PERF_COUNT_EN to add the instr_count port and
// a 16-bit wrapping count of valid IR loads.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   start          one-cycle pulse, leaves IDLE
//   stall          hold PC and IR
//   branch_taken   IR instruction resolved taken; branch_target is the new PC
//   instr_in       ROM data for pc_out
//   pc_out         ROM address / fetch PC
//   ir_out, ir_pc  latched instruction and the PC it came from
//   ir_valid       ir_out holds a real instruction
//   halted         high in HALT
//   instr_count    fetched-instruction counter (FETCH_PERF_COUNT_EN only)
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [INSTR_W-1:0] HALT_INSTR = HALT_INSTR_ENC,
  parameter logic [PC_W-1:0]    RESET_PC   = 16'd0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [PC_W-1:0]    pc_out,
  output logic [INSTR_W-1:0] ir_out,
  output logic [PC_W-1:0]    ir_pc,
  output logic               ir_valid,
  output logic               halted
`ifdef FETCH_PERF_COUNT_EN
  ,
  output logic [15:0]        instr_count
`endif
);

  fetch_state_e       r_state;
  fetch_state_e       w_state_nxt;
  logic               w_branch;
  logic               w_fetch;
  logic               w_pc_inc;
  logic [PC_W-1:0]    w_pc;
  logic [INSTR_W-1:0] r_ir;
  logic [PC_W-1:0]    r_ir_pc;
  logic               r_ir_valid;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_branch),
    .i_target (branch_target),
    .i_inc    (w_pc_inc),
    .o_pc     (w_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Branch beats stall; a word fetched as the halt instruction still loads the
  // IR but freezes the PC on the halt address.
  always_comb begin
    w_state_nxt = r_state;
    w_branch    = 1'b0;
    w_fetch     = 1'b0;
    w_pc_inc    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (branch_taken) begin
          w_branch = 1'b1;
        end else if (!stall) begin
          w_fetch = 1'b1;
          if (instr_in == HALT_INSTR) begin
            w_state_nxt = ST_HALT;
          end else begin
            w_pc_inc = 1'b1;
          end
        end
      end
      ST_HALT: begin
        w_state_nxt = ST_HALT;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // IR: load on fetch; valid drops on a branch (squash) and in HALT so the halt
  // word is presented for exactly one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ir       <= '0;
      r_ir_pc    <= '0;
      r_ir_valid <= 1'b0;
    end else if (w_fetch) begin
      r_ir       <= instr_in;
      r_ir_pc    <= w_pc;
      r_ir_valid <= 1'b1;
    end else if (w_branch || (r_state == ST_HALT)) begin
      r_ir_valid <= 1'b0;
    end
  end

`ifdef FETCH_PERF_COUNT_EN
  logic [15:0] r_instr_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr_count <= '0;
    end else if (w_fetch) begin
      r_instr_count <= r_instr_count + 16'd1;
    end
  end

  assign instr_count = r_instr_count;
`endif

  assign pc_out   = w_pc;
  assign ir_out   = r_ir;
  assign ir_pc    = r_ir_pc;
  assign ir_valid = r_ir_valid;
  assign halted   = (r_state == ST_HALT);

endmodule
